// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, with valid/ack handshake and framing/overrun flags.
// Optional RX_MAJORITY_VOTE_EN: 3-sample majority filter on the synchronised line.
module uart_receiver #(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int DIV  = comm_clk_frequency / baud_rate;
  localparam int HALF = DIV / 2;

  localparam logic [15:0] BIT_LAST   = 16'(DIV - 1);
  localparam logic [15:0] START_LAST = 16'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bidx, bidx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  rx_data_n;
  logic        rx_valid_n;
  logic        frame_err_n;
  logic        overrun_n;

  logic rxd_meta;
  logic rxd_sync;
  logic rx_in;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking here keeps the two flops distinct stages;
      // blocking would collapse them into a single register.
      rxd_meta <= RxD;
      rxd_sync <= rxd_meta;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  // Majority of the last three synced samples. Feeding the whole FSM from the
  // filtered line delays every decision by one clock while keeping the vote
  // window centred on the same cycle the unfiltered build would sample.
  logic [1:0] rxd_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_hist <= 2'b11;
    end else begin
      rxd_hist <= {rxd_hist[0], rxd_sync};
    end
  end

  assign rx_in = (rxd_sync    & rxd_hist[0]) |
                 (rxd_sync    & rxd_hist[1]) |
                 (rxd_hist[0] & rxd_hist[1]);
`else
  assign rx_in = rxd_sync;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      // NOTE: the shift register is reset along with everything else so a
      // frame aborted by reset can never leak a partial byte.
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    bidx_n      = bidx;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid & ~rx_ack;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_in) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        if (cnt == START_LAST) begin
          if (rx_in) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            cnt_n   = '0;
            bidx_n  = '0;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          shreg_n = {rx_in, shreg[7:1]};
          cnt_n   = '0;
          if (bidx == 3'd7) begin
            state_n = STOP;
          end else begin
            bidx_n = bidx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_in) begin
            // New data wins; an ack landing on this very cycle consumes the old byte.
            rx_data_n  = shreg;
            rx_valid_n = 1'b1;
            overrun_n  = rx_valid & ~rx_ack;
            state_n    = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      WAIT_HIGH: begin
        if (rx_in) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIV=16: handshake, glitch reject, framing
// error, overrun, same-cycle ack, mid-frame reset and the bit-0 glitch case.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int n_cmp = 0;
  int n_err = 0;
  int fe_pulses = 0;
  int ov_pulses = 0;

`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOTE_LAG = 1;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int VOTE_LAG = 0;
  localparam logic [7:0] GLITCH_EXP = 8'hFE;
`endif

  uart_receiver #(
    .comm_clk_frequency(1_600_000),
    .baud_rate         (100_000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (RxD),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_pulses++;
    if (overrun === 1'b1)   ov_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    RxD = v;
    tick(n);
  endtask

  task automatic send_head(input logic [7:0] d, input int nbits);
    drive(1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(d[i], 16);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_head(d, 8);
    drive(stop, 16);
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    RxD    = 1'b1;
    rx_ack = 1'b0;
    reset  = 1'b0;
    tick(3);
    check("rst_data",  rx_data,   32'h00);
    check("rst_valid", rx_valid,  32'h0);
    check("rst_busy",  rx_busy,   32'h0);
    check("rst_ferr",  frame_err, 32'h0);
    check("rst_ovr",   overrun,   32'h0);
    reset = 1'b1;
    tick(4);

    // 1: plain byte, then ack clears rx_valid on the next cycle
    send_byte(8'h55, 1'b1);
    check("t1_valid", rx_valid, 32'h1);
    check("t1_data",  rx_data,  32'h55);
    tick(5);
    ack_once();
    check("t1_valid_clr", rx_valid, 32'h0);
    rx_ack = 1'b1;
    tick(2);
    rx_ack = 1'b0;
    check("t1_idle_ack", rx_valid, 32'h0);
    check("t1_flags", fe_pulses + ov_pulses, 32'd0);

    // 2: short low glitch is rejected at the start-bit centre
    drive(1'b0, 4);
    RxD = 1'b1;
    tick(2);
    check("t2_busy", rx_busy, 32'h1);
    tick(10);
    check("t2_idle",  rx_busy,   32'h0);
    check("t2_valid", rx_valid,  32'h0);
    check("t2_ferr",  fe_pulses, 32'd0);

    // 3: bad stop bit followed by a long break, then a good byte
    send_head(8'hA5, 8);
    drive(1'b0, 56);
    check("t3_ferr_cnt", fe_pulses, 32'd1);
    check("t3_brk_busy", rx_busy,   32'h1);
    RxD = 1'b1;
    tick(20);
    check("t3_idle",  rx_busy,  32'h0);
    check("t3_valid", rx_valid, 32'h0);
    check("t3_data",  rx_data,  32'h55);
    send_byte(8'h3C, 1'b1);
    check("t3_good_data",  rx_data,   32'h3C);
    check("t3_good_valid", rx_valid,  32'h1);
    check("t3_ferr_once",  fe_pulses, 32'd1);
    ack_once();

    // 4: two bytes back-to-back without ack
    send_byte(8'h01, 1'b1);
    check("t4_first", rx_data, 32'h01);
    send_byte(8'h02, 1'b1);
    check("t4_ovr",   ov_pulses, 32'd1);
    check("t4_data",  rx_data,   32'h02);
    check("t4_valid", rx_valid,  32'h1);

    // 4b: ack in the completion cycle keeps rx_valid and suppresses overrun
    send_head(8'h81, 8);
    RxD = 1'b1;
    tick(10 + VOTE_LAG);
    ack_once();
    check("t4b_valid", rx_valid,  32'h1);
    check("t4b_data",  rx_data,   32'h81);
    check("t4b_ovr",   ov_pulses, 32'd1);
    tick(5);

    // 5: reset in the middle of bit 4 of 0xF0
    send_head(8'hF0, 4);
    drive(1'b1, 8);
    reset = 1'b0;
    #1;
    check("t5_data",  rx_data,   32'h00);
    check("t5_valid", rx_valid,  32'h0);
    check("t5_busy",  rx_busy,   32'h0);
    check("t5_ferr",  frame_err, 32'h0);
    check("t5_ovr",   overrun,   32'h0);
    RxD = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(5);
    check("t5_rel_busy",  rx_busy,  32'h0);
    check("t5_rel_valid", rx_valid, 32'h0);
    send_byte(8'h3C, 1'b1);
    check("t5_after_data",  rx_data,  32'h3C);
    check("t5_after_valid", rx_valid, 32'h1);
    ack_once();

    // 6: 0xFF with a one-clock low glitch exactly at the bit-0 sample point
    drive(1'b0, 16);
    drive(1'b1, 8);
    drive(1'b0, 1);
    drive(1'b1, 7);
    for (int i = 1; i < 8; i++) drive(1'b1, 16);
    drive(1'b1, 16);
    check("t6_data",  rx_data,  32'(GLITCH_EXP));
    check("t6_valid", rx_valid, 32'h1);

    check("end_ferr", fe_pulses, 32'd1);
    check("end_ovr",  ov_pulses, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
